// File: rtl/multiplier_result_fifo_taint.sv
// -----------------------------------------------------------------------------
// multiplier_result_fifo_taint
//
// Purpose:
//   Captures each completed product from the taint-tracked sequential
//   multiplier on the rising edge of productDone and buffers it in a small
//   FIFO that drains to the consumer through a valid/ready handshake.
//   Per-bit taint follows the data, and control taint is tracked
//   conservatively. When a capture or drain decision is itself tainted, the
//   occupancy state and any data written under it become tainted too.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous, active-low reset
//   product        product from the multiplier (2*WIDTH bits)
//   product_t      per-bit taint of product
//   productDone    level-high while product is valid
//   productDone_t  taint of productDone
//   out_ready      consumer accepts the head entry this cycle
//   out_ready_t    taint of out_ready
//   out_valid      FIFO non-empty; head entry presented
//   out_valid_t    taint of out_valid
//   out_product    head entry data
//   out_product_t  head entry per-bit taint
//   count          occupancy, 0..DEPTH
//   count_t        taint of count and of both pointers
//   overflow       sticky: a capture was dropped because the FIFO was full
//   overflow_t     taint of overflow
// -----------------------------------------------------------------------------
module multiplier_result_fifo_taint #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2*WIDTH-1:0]         product,
    input  logic [2*WIDTH-1:0]         product_t,
    input  logic                       productDone,
    input  logic                       productDone_t,
    input  logic                       out_ready,
    input  logic                       out_ready_t,
    output logic                       out_valid,
    output logic                       out_valid_t,
    output logic [2*WIDTH-1:0]         out_product,
    output logic [2*WIDTH-1:0]         out_product_t,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       count_t,
    output logic                       overflow,
    output logic                       overflow_t
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = 2 * WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Replicate one control-taint bit across a full data word.
    function automatic logic [DW-1:0] spread_taint(input logic t);
        spread_taint = {DW{t}};
    endfunction

    // State registers
    logic           done_q,       done_d;
    logic           done_t_q,     done_t_d;
    logic [PW-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q,     rd_ptr_d;
    logic [CW-1:0]  count_q,      count_d;
    logic           count_t_q,    count_t_d;
    logic           overflow_q,   overflow_d;
    logic           overflow_t_q, overflow_t_d;
    logic [DW-1:0]  mem_q   [DEPTH];
    logic [DW-1:0]  mem_d   [DEPTH];
    logic [DW-1:0]  mem_t_q [DEPTH];
    logic [DW-1:0]  mem_t_d [DEPTH];

    // Per-cycle decisions
    logic push_s, push_t_s;
    logic pop_s, pop_t_s;
    logic full_s, valid_s;
    logic accept_s;

    // Edge detect, handshake and occupancy decisions with their taint.
    always_comb begin
        full_s   = (count_q == DEPTH_C);
        valid_s  = (count_q != {CW{1'b0}});
        push_s   = productDone & ~done_q;
        push_t_s = productDone_t | done_t_q;
        pop_s    = valid_s & out_ready;
        pop_t_s  = count_t_q | out_ready_t;
        // A pop in the same cycle frees the slot the full-FIFO push needs.
        accept_s = push_s & (~full_s | pop_s);
    end

    // Next-state for pointers, count, sticky flags and all taint state.
    always_comb begin
        done_d       = productDone;
        done_t_d     = productDone_t;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        mem_d        = mem_q;
        mem_t_d      = mem_t_q;

        if (accept_s) begin
            mem_d[wr_ptr_q]   = product;
            mem_t_d[wr_ptr_q] = product_t | spread_taint(push_t_s | count_t_q);
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({accept_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (push_s & full_s & ~pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        count_t_d    = count_t_q | push_t_s | (pop_t_s & (valid_s | out_ready));
        // Overflow is tainted if a push might have happened against a
        // possibly-full FIFO and at least one of those facts is tainted.
        overflow_t_d = overflow_t_q
                     | ((push_s | push_t_s) & (full_s | count_t_q) & (push_t_s | count_t_q));
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q       <= 1'b0;
            done_t_q     <= 1'b0;
            wr_ptr_q     <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            count_q      <= {CW{1'b0}};
            count_t_q    <= 1'b0;
            overflow_q   <= 1'b0;
            overflow_t_q <= 1'b0;
        end else begin
            done_q       <= done_d;
            done_t_q     <= done_t_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            count_t_q    <= count_t_d;
            overflow_q   <= overflow_d;
            overflow_t_q <= overflow_t_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        mem_q   <= mem_d;
        mem_t_q <= mem_t_d;
    end

    // Output mapping from registered state.
    always_comb begin
        out_valid     = valid_s;
        out_valid_t   = count_t_q;
        out_product   = mem_q[rd_ptr_q];
        out_product_t = mem_t_q[rd_ptr_q] | spread_taint(count_t_q);
        count         = count_q;
        count_t       = count_t_q;
        overflow      = overflow_q;
        overflow_t    = overflow_t_q;
    end

endmodule

// File: tb/tb_multiplier_result_fifo_taint.sv
module tb_multiplier_result_fifo_taint;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       product, product_t;
    logic             productDone, productDone_t;
    logic             out_ready, out_ready_t;
    logic             out_valid, out_valid_t;
    logic [7:0]       out_product, out_product_t;
    logic [1:0]       count;
    logic             count_t, overflow, overflow_t;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    multiplier_result_fifo_taint #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .product(product), .product_t(product_t),
        .productDone(productDone), .productDone_t(productDone_t),
        .out_ready(out_ready), .out_ready_t(out_ready_t),
        .out_valid(out_valid), .out_valid_t(out_valid_t),
        .out_product(out_product), .out_product_t(out_product_t),
        .count(count), .count_t(count_t),
        .overflow(overflow), .overflow_t(overflow_t)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        product = 8'h00; product_t = 8'h00;
        productDone = 1'b0; productDone_t = 1'b0;
        out_ready = 1'b0; out_ready_t = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    // One productDone edge carrying value v: high for one cycle, then low.
    task automatic pulse(input logic [7:0] v);
        product = v; productDone = 1'b1;
        tick();
        productDone = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++; if ({out_valid, out_valid_t, count, count_t, overflow, overflow_t} !== 7'b0)
            $display("FAIL reset_state got=%b want=0000000", {out_valid, out_valid_t, count, count_t, overflow, overflow_t});
        else pass_cnt++;
    endtask

    task automatic test_single_capture();
        do_reset();
        product = 8'h2A; productDone = 1'b1;
        tick();
        chk_cnt++; if (count !== 2'd1) $display("FAIL single_count got=%0d want=1", count); else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b1 || out_product !== 8'h2A)
            $display("FAIL single_head got=%b/%h want=1/2a", out_valid, out_product); else pass_cnt++;
        tick(); tick();
        chk_cnt++; if (count !== 2'd1) $display("FAIL held_done_one_push got=%0d want=1", count); else pass_cnt++;
        chk_cnt++; if ({out_valid_t, out_product_t, count_t, overflow_t} !== 11'b0)
            $display("FAIL single_taint got=%b want=0", {out_valid_t, out_product_t, count_t, overflow_t}); else pass_cnt++;
        productDone = 1'b0;
        tick();
    endtask

    task automatic test_overflow_drain();
        do_reset();
        pulse(8'h01); pulse(8'h02); pulse(8'h03);
        chk_cnt++; if (count !== 2'd2 || overflow !== 1'b1)
            $display("FAIL ovf_full got=%0d/%b want=2/1", count, overflow); else pass_cnt++;
        chk_cnt++; if (out_product !== 8'h01) $display("FAIL ovf_head got=%h want=01", out_product); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        chk_cnt++; if (count !== 2'd1 || out_product !== 8'h02)
            $display("FAIL drain1 got=%0d/%h want=1/02", count, out_product); else pass_cnt++;
        tick();
        chk_cnt++; if (count !== 2'd0 || out_valid !== 1'b0)
            $display("FAIL drain2 got=%0d/%b want=0/0", count, out_valid); else pass_cnt++;
        tick();
        chk_cnt++; if (count !== 2'd0 || overflow !== 1'b1)
            $display("FAIL no_underflow got=%0d/%b want=0/1", count, overflow); else pass_cnt++;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        pulse(8'h11); pulse(8'h22);
        product = 8'h77; productDone = 1'b1; out_ready = 1'b1;
        tick();
        productDone = 1'b0;
        chk_cnt++; if (count !== 2'd2 || overflow !== 1'b0)
            $display("FAIL full_push_pop got=%0d/%b want=2/0", count, overflow); else pass_cnt++;
        chk_cnt++; if (out_product !== 8'h22) $display("FAIL b2b_head1 got=%h want=22", out_product); else pass_cnt++;
        tick();
        chk_cnt++; if (out_product !== 8'h77 || count !== 2'd1)
            $display("FAIL b2b_head2 got=%h/%0d want=77/1", out_product, count); else pass_cnt++;
        tick();
        chk_cnt++; if (count !== 2'd0) $display("FAIL b2b_empty got=%0d want=0", count); else pass_cnt++;
        out_ready = 1'b0;
    endtask

    task automatic test_data_taint();
        do_reset();
        product_t = 8'h0F;
        pulse(8'h5A);
        product_t = 8'h00;
        chk_cnt++; if (out_product !== 8'h5A || out_product_t !== 8'h0F)
            $display("FAIL data_taint got=%h/%h want=5a/0f", out_product, out_product_t); else pass_cnt++;
        chk_cnt++; if ({out_valid_t, count_t, overflow_t} !== 3'b000)
            $display("FAIL data_taint_ctrl got=%b want=000", {out_valid_t, count_t, overflow_t}); else pass_cnt++;
    endtask

    task automatic test_ctrl_taint();
        do_reset();
        product = 8'h33; productDone = 1'b1; productDone_t = 1'b1;
        tick();
        productDone = 1'b0; productDone_t = 1'b0;
        chk_cnt++; if (out_product_t !== 8'hFF || count_t !== 1'b1 || out_valid_t !== 1'b1)
            $display("FAIL ctrl_taint got=%h/%b/%b want=ff/1/1", out_product_t, count_t, out_valid_t); else pass_cnt++;
        chk_cnt++; if (overflow_t !== 1'b0) $display("FAIL ovf_t_first got=%b want=0", overflow_t); else pass_cnt++;
        tick();
        // done_q_t still set makes push tainted while count_t is set
        chk_cnt++; if (overflow_t !== 1'b1) $display("FAIL ovf_t_conservative got=%b want=1", overflow_t); else pass_cnt++;
        out_ready = 1'b1;
        tick(); tick();
        chk_cnt++; if (count_t !== 1'b1 || out_valid_t !== 1'b1 || out_product_t !== 8'hFF)
            $display("FAIL ctrl_taint_sticky got=%b/%b/%h want=1/1/ff", count_t, out_valid_t, out_product_t); else pass_cnt++;
        out_ready = 1'b0;
        do_reset();
        chk_cnt++; if ({count_t, out_valid_t, overflow_t} !== 3'b000)
            $display("FAIL taint_cleared got=%b want=000", {count_t, out_valid_t, overflow_t}); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        pulse(8'h01); pulse(8'h02);
        out_ready = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk_cnt++; if ({out_valid, count, overflow, out_valid_t, count_t, overflow_t} !== 7'b0)
            $display("FAIL async_reset got=%b want=0", {out_valid, count, overflow, out_valid_t, count_t, overflow_t}); else pass_cnt++;
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        pulse(8'h9C); pulse(8'hC9);
        chk_cnt++; if (out_product !== 8'h9C || count !== 2'd2)
            $display("FAIL post_reset_entry0 got=%h/%0d want=9c/2", out_product, count); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_cnt++; if (out_product !== 8'hC9 || count !== 2'd1)
            $display("FAIL post_reset_order got=%h/%0d want=c9/1", out_product, count); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_overflow_drain();
        test_back_to_back();
        test_data_taint();
        test_ctrl_taint();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
